dm_lsu: RTL and testbench

- Data-memory load/store unit of the DM (memory) stage.
- Consumes the EX/DM pipeline-register outputs (ALU result as address, rs2 value as store data, instruction funct3, memory read/write controls).
- Runs a request/grant/response transaction on the data bus and returns sign- or zero-extended load data to the DM/WB register.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dm_lsu_if.sv | 18 +
 rtl/dm_lsu_align.sv | 40 ++++
 rtl/dm_lsu.sv | 132 +++++++++++++
 tb/tb_dm_lsu.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared LSU types: FSM states, funct3 width/sign codes and the byte-enable generator.
// No logic of its own. The aligned byte-enable pattern comes from funct3 and addr[1:0].
package dm_pkg;

    localparam int DM_XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_HOLD,
        S_DRAIN
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Half accesses use only addr[1] and word accesses ignore addr[1:0], so odd addresses truncate.
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b00:   be_gen = 4'b0001 << addr;
            2'b01:   be_gen = addr[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Data-bus request/grant/response bundle. The LSU drives it through the master modport.
// Backpressure: req and its fields are held until gnt; rvalid arrives at the earliest one cycle after gnt.
interface dm_lsu_if;
    import dm_pkg::*;

    logic               req;
    logic               we;
    logic [DM_XLEN-1:0] addr;
    logic [3:0]         be;
    logic [DM_XLEN-1:0] wdata;
    logic               gnt;
    logic               rvalid;
    logic [DM_XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dm_lsu_align.sv
// Combinational lane steering: store data replication with byte enables, and load extract with sign/zero extend.
// Zero latency and no flow control.
module dm_lsu_align
    import dm_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic [DM_XLEN-1:0] wdata,
    input  logic [DM_XLEN-1:0] rdata,
    output logic [3:0]         be,
    output logic [DM_XLEN-1:0] wdata_sh,
    output logic [DM_XLEN-1:0] rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be     = be_gen(funct3, addr_lo);
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3[1:0])
            2'b00:   wdata_sh = {4{wdata[7:0]}};
            2'b01:   wdata_sh = {2{wdata[15:0]}};
            default: wdata_sh = wdata;
        endcase

        // The remaining funct3 codes (011, 110, 111) fall through to a full word.
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_v[7]}}, byte_v};
            F3_BU:   rdata_ext = {24'b0, byte_v};
            F3_H:    rdata_ext = {{16{half_v[15]}}, half_v};
            F3_HU:   rdata_ext = {16'b0, half_v};
            F3_W:    rdata_ext = rdata;
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// DM-stage load/store unit. A store stalls 0 cycles; a load stalls 1 cycle at best. Result is held until advance.
// Stalls while the bus withholds gnt or rvalid. DM_LSU_MISALIGN_TRAP_EN flags misaligned accesses instead of truncating them.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    input  logic            m_mem_rd,
    input  logic            m_mem_wr,
    input  logic [XLEN-1:0] m_addr,
    input  logic [XLEN-1:0] m_wdata,
    input  logic [2:0]      m_funct3,
    output logic [XLEN-1:0] m_rdata,
    output logic            m_done,
    output logic            m_stall,
    output logic            m_misalign,
    dm_lsu_if.master        dbus
);

    lsu_state_t      state, state_nxt;
    logic            access, is_load, is_store, mis;
    logic            req, stall, capture, misalign_set, misalign_q;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_sh, rdata_ext;

    dm_lsu_align u_align (
        .funct3    (m_funct3),
        .addr_lo   (m_addr[1:0]),
        .wdata     (m_wdata),
        .rdata     (dbus.rdata),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    assign access   = m_mem_rd | m_mem_wr;
    assign is_load  = m_mem_rd;
    assign is_store = m_mem_wr & ~m_mem_rd;

`ifdef DM_LSU_MISALIGN_TRAP_EN
    assign mis = ((m_funct3[1:0] == 2'b01) & m_addr[0]) | (m_funct3[1] & (|m_addr[1:0]));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        req          = 1'b0;
        stall        = 1'b0;
        capture      = 1'b0;
        misalign_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (access && !clear) begin
                    if (mis) begin
                        misalign_set = 1'b1;
                        state_nxt    = S_HOLD;
                    end else begin
                        req   = 1'b1;
                        stall = !(is_store && dbus.gnt);
                        if (dbus.gnt)
                            state_nxt = is_load ? S_RESP : (advance ? S_IDLE : S_HOLD);
                        else
                            state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                end else begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (dbus.gnt)
                        state_nxt = is_load ? S_RESP : S_HOLD;
                end
            end
            S_RESP: begin
                // The response cycle itself does not stall; the extended data is registered at this edge.
                stall = !dbus.rvalid;
                if (dbus.rvalid) begin
                    capture   = !clear;
                    state_nxt = clear ? S_IDLE : S_HOLD;
                end else if (clear) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (dbus.rvalid)
                    state_nxt = S_IDLE;
            end
            S_HOLD: begin
                if (advance || clear)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            m_rdata    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture)
                m_rdata <= rdata_ext;
            else if (misalign_set)
                m_rdata <= '0;
            if (misalign_set)
                misalign_q <= 1'b1;
            else if (state == S_HOLD && (advance || clear))
                misalign_q <= 1'b0;
        end
    end

    assign m_done     = (state == S_HOLD);
    assign m_misalign = misalign_q;
    assign m_stall    = stall & ~reset;
    assign dbus.req   = req & ~reset;
    assign dbus.we    = is_store;
    assign dbus.addr  = {m_addr[XLEN-1:2], 2'b00};
    assign dbus.be    = be;
    assign dbus.wdata = wdata_sh;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed scoreboard bench for dm_lsu: stimulus queues the expected bus requests and results, and a negedge monitor checks them.
module tb_dm_lsu;
    import dm_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        misalign;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        reset, clear, advance, m_mem_rd, m_mem_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_funct3;
    logic        m_done, m_stall, m_misalign;

    dm_lsu_if dbus ();

    dm_lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .advance    (advance),
        .m_mem_rd   (m_mem_rd),
        .m_mem_wr   (m_mem_wr),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_funct3   (m_funct3),
        .m_rdata    (m_rdata),
        .m_done     (m_done),
        .m_stall    (m_stall),
        .m_misalign (m_misalign),
        .dbus       (dbus)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_fail = 0;
    int        req_cycles;
    int        dcyc;
    bus_exp_t  exp_bus[$];
    done_exp_t exp_done[$];
    logic      prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus_exp_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd;
        exp_bus.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] rd, input logic chk_rd, input logic mis);
        done_exp_t e;
        e.rdata = rd; e.chk_rdata = chk_rd; e.misalign = mis;
        exp_done.push_back(e);
    endtask

    always @(negedge clk) begin
        bus_exp_t  b;
        done_exp_t d;
        if (!reset) begin
            if (dbus.req && dbus.gnt) begin
                if (exp_bus.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL bus_unexp: got req addr %h want none", dbus.addr);
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus_we", {31'b0, dbus.we}, {31'b0, b.we});
                    chk("bus_addr", dbus.addr, b.addr);
                    chk("bus_be", {28'b0, dbus.be}, {28'b0, b.be});
                    chk("bus_wdata", dbus.wdata, b.wdata);
                end
            end
            if (m_done && !prev_done) begin
                if (exp_done.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL done_unexp: got done rdata %h want none", m_rdata);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_misalign", {31'b0, m_misalign}, {31'b0, d.misalign});
                    if (d.chk_rdata) chk("done_rdata", m_rdata, d.rdata);
                end
            end
        end
        prev_done = m_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access, play gnt/rvalid at the given delays, check stall count, then retire it.
    task automatic run_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input int gnt_dly,
                              input int rv_dly, input logic [31:0] rresp, input int exp_stall,
                              output int done_cyc);
        int cyc = 0;
        int n_stall = 0;
        bit done = 0;
        m_mem_rd = rd; m_mem_wr = wr; m_funct3 = f3; m_addr = addr; m_wdata = wdata;
        advance = 0; clear = 0; req_cycles = 0;
        while (!done && cyc < 40) begin
            dbus.gnt    = (cyc == gnt_dly);
            dbus.rvalid = rd && (cyc == gnt_dly + rv_dly);
            dbus.rdata  = dbus.rvalid ? rresp : 32'h0BAD_0BAD;
            @(negedge clk);
            if (m_stall) n_stall++;
            if (dbus.req) req_cycles++;
            if (m_done) done = 1;
            step();
            if (!done) cyc++;
        end
        done_cyc = cyc;
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
        chk({nm, "_stall"}, n_stall, exp_stall);
        dbus.gnt = 0; dbus.rvalid = 0; advance = 1;
        step();
        m_mem_rd = 0; m_mem_wr = 0; advance = 0;
        @(negedge clk);
        chk({nm, "_idle_req"}, {31'b0, dbus.req}, 32'd0);
        chk({nm, "_idle_done"}, {31'b0, m_done}, 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; clear = 0; advance = 0; m_mem_rd = 0; m_mem_wr = 0;
        m_addr = 0; m_wdata = 0; m_funct3 = 0;
        dbus.gnt = 0; dbus.rvalid = 0; dbus.rdata = 0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req", {31'b0, dbus.req}, 32'd0);
        chk("rst_stall", {31'b0, m_stall}, 32'd0);
        chk("rst_done", {31'b0, m_done}, 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_misalign", {31'b0, m_misalign}, 32'd0);
        step();
        reset = 0;
        step();

        push_bus(1, 32'h104, 4'b1111, 32'hDEADBEEF);
        push_done(0, 0, 0);
        run_access("sw", 0, 1, F3_W, 32'h104, 32'hDEADBEEF, 0, 1, 0, 0, dcyc);
        chk("sw_done_cyc", dcyc, 1);

        push_bus(0, 32'h200, 4'b1000, 0);
        push_done(32'hFFFFFF80, 1, 0);
        run_access("lb", 1, 0, F3_B, 32'h203, 0, 0, 1, 32'h80FFFFFF, 1, dcyc);

        push_bus(0, 32'h200, 4'b1000, 0);
        push_done(32'h00000080, 1, 0);
        run_access("lbu", 1, 0, F3_BU, 32'h203, 0, 0, 1, 32'h80FFFFFF, 1, dcyc);

        push_bus(0, 32'h10, 4'b0011, 0);
        push_done(32'hFFFFABCD, 1, 0);
        run_access("lh", 1, 0, F3_H, 32'h10, 0, 3, 2, 32'h1234ABCD, 5, dcyc);
        chk("lh_req_cycles", req_cycles, 4);

        push_bus(1, 32'h100, 4'b0100, 32'h78787878);
        push_done(0, 0, 0);
        run_access("sb", 0, 1, F3_B, 32'h102, 32'h12345678, 1, 1, 0, 2, dcyc);

        push_bus(0, 32'h10, 4'b1100, 0);
        push_done(32'h00008001, 1, 0);
        run_access("lhu", 1, 0, F3_HU, 32'h12, 0, 0, 3, 32'h80010000, 3, dcyc);

        push_bus(0, 32'h8, 4'b1111, 0);
        push_done(32'hCAFEF00D, 1, 0);
        run_access("lw111", 1, 0, 3'b111, 32'h8, 0, 0, 1, 32'hCAFEF00D, 1, dcyc);

`ifdef DM_LSU_MISALIGN_TRAP_EN
        push_done(32'h0, 1, 1);
`else
        push_bus(1, 32'h300, 4'b0011, 32'hCAFECAFE);
        push_done(0, 0, 0);
`endif
        run_access("sh_mis", 0, 1, F3_H, 32'h301, 32'h0000CAFE, 0, 1, 0, 0, dcyc);
        chk("sh_mis_flag_clr", {31'b0, m_misalign}, 32'd0);

        // Store granted while the pipeline advances retires with no hold cycle.
        m_mem_wr = 1; m_funct3 = F3_W; m_addr = 32'h108; m_wdata = 32'h0BADF00D;
        dbus.gnt = 1; advance = 1;
        push_bus(1, 32'h108, 4'b1111, 32'h0BADF00D);
        @(negedge clk);
        chk("stadv_stall", {31'b0, m_stall}, 32'd0);
        step();
        m_mem_wr = 0; dbus.gnt = 0; advance = 0;
        @(negedge clk);
        chk("stadv_done", {31'b0, m_done}, 32'd0);
        step();

        // Flush while a load is outstanding: drain the response, never report it.
        m_mem_rd = 1; m_funct3 = F3_W; m_addr = 32'h40; m_wdata = 0; dbus.gnt = 1;
        push_bus(0, 32'h40, 4'b1111, 0);
        @(negedge clk);
        chk("drain_gnt_stall", {31'b0, m_stall}, 32'd1);
        step();
        dbus.gnt = 0; clear = 1; m_mem_rd = 0;
        @(negedge clk);
        chk("drain_clr_stall", {31'b0, m_stall}, 32'd1);
        step();
        clear = 0;
        @(negedge clk);
        chk("drain_wait_stall", {31'b0, m_stall}, 32'd1);
        chk("drain_wait_done", {31'b0, m_done}, 32'd0);
        step();
        dbus.rvalid = 1; dbus.rdata = 32'h00000055;
        @(negedge clk);
        chk("drain_rv_stall", {31'b0, m_stall}, 32'd1);
        step();
        dbus.rvalid = 0;
        @(negedge clk);
        chk("drain_end_stall", {31'b0, m_stall}, 32'd0);
        chk("drain_end_done", {31'b0, m_done}, 32'd0);
        step();

        push_bus(0, 32'h200, 4'b0010, 0);
        push_done(32'h000000AB, 1, 0);
        run_access("post_drain_lbu", 1, 0, F3_BU, 32'h201, 0, 0, 1, 32'h0000AB00, 1, dcyc);

        // Reset while a request is pending in REQ; a stray rvalid afterwards is ignored.
        m_mem_rd = 1; m_funct3 = F3_W; m_addr = 32'h504; dbus.gnt = 0;
        @(negedge clk);
        chk("rstreq_idle_req", {31'b0, dbus.req}, 32'd1);
        step();
        @(negedge clk);
        chk("rstreq_req_req", {31'b0, dbus.req}, 32'd1);
        step();
        reset = 1;
        step();
        reset = 0; m_mem_rd = 0; dbus.rvalid = 1; dbus.rdata = 32'h77;
        @(negedge clk);
        chk("rstreq_req", {31'b0, dbus.req}, 32'd0);
        chk("rstreq_stall", {31'b0, m_stall}, 32'd0);
        chk("rstreq_done", {31'b0, m_done}, 32'd0);
        chk("rstreq_rdata", m_rdata, 32'd0);
        chk("rstreq_misalign", {31'b0, m_misalign}, 32'd0);
        step();
        dbus.rvalid = 0;
        @(negedge clk);
        chk("rstreq_rv_ignored", {31'b0, m_done}, 32'd0);
        step();

        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
